// File: rtl/ppm_sram_writer_pkg.sv
// Shared definitions for the PPM image loader and the VGA read path:
// FSM state encoding, the PPM header line terminator and the frame geometry.
package ppm_sram_writer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  localparam logic [7:0] PPM_LF = 8'h0A;

  // 320x240 RGB, two bytes per SRAM word
  localparam int FRAME_WIDTH  = 320;
  localparam int FRAME_HEIGHT = 240;
  localparam int FRAME_WORDS  = FRAME_WIDTH * FRAME_HEIGHT * 3 / 2;

endpackage

// File: rtl/ppm_sram_writer_if.sv
// Byte-stream input and SRAM write-port bundle of the PPM loader.
// slave is the writer's view, master is the view of whoever feeds bytes
// and observes the SRAM side.
interface ppm_sram_writer_if;

  logic        Enable;
  logic        Byte_valid;
  logic [7:0]  Byte_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [16:0] Word_count;
  logic        Busy;
  logic        Done;

  modport master (
    output Enable, Byte_valid, Byte_data,
    input  SRAM_address, SRAM_write_data, SRAM_we_n, Word_count, Busy, Done
  );

  modport slave (
    input  Enable, Byte_valid, Byte_data,
    output SRAM_address, SRAM_write_data, SRAM_we_n, Word_count, Busy, Done
  );

endinterface

// File: rtl/ppm_sram_writer.sv
// Loads a binary PPM byte stream into SRAM: skips the text header (a fixed
// number of LF-terminated lines), packs payload bytes big-endian into 16-bit
// words and writes them to consecutive SRAM addresses with a one-cycle
// active-low write strobe.
module ppm_sram_writer
  import ppm_sram_writer_pkg::*;
#(
  parameter logic [17:0] BASE_ADDRESS = 18'd0,
  parameter int          HEADER_LINES = 3,
  parameter int          NUM_WORDS    = FRAME_WORDS
) (
  input  logic             Clock_50,
  input  logic             Resetn,
  ppm_sram_writer_if.slave bus
);

  localparam logic [7:0]  LF_LAST   = 8'(HEADER_LINES - 1);
  localparam logic [16:0] LAST_WORD = 17'(NUM_WORDS - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  lf_count;
  logic [7:0]  hold;
  logic [17:0] address;
  logic [15:0] write_data;
  logic        we_n;
  logic [16:0] word_count;
  logic        busy;
  logic        done;

  logic        start_session;
  logic        count_lf;
  logic        load_hold;
  logic        issue_write;

  // State register
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next-state and per-cycle control strobes; Enable low aborts any active phase
  always_comb begin
    next_state    = state;
    start_session = 1'b0;
    count_lf      = 1'b0;
    load_hold     = 1'b0;
    issue_write   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.Enable) begin
          next_state    = S_HEADER;
          start_session = 1'b1;
        end
      end
      S_HEADER: begin
        if (!bus.Enable) begin
          next_state = S_IDLE;
        end else if (bus.Byte_valid && (bus.Byte_data == PPM_LF)) begin
          count_lf = 1'b1;
          if (lf_count == LF_LAST) next_state = S_HIGH;
        end
      end
      S_HIGH: begin
        if (!bus.Enable) begin
          next_state = S_IDLE;
        end else if (bus.Byte_valid) begin
          load_hold  = 1'b1;
          next_state = S_LOW;
        end
      end
      S_LOW: begin
        if (!bus.Enable) begin
          next_state = S_IDLE;
        end else if (bus.Byte_valid) begin
          issue_write = 1'b1;
          next_state  = (word_count == LAST_WORD) ? S_DONE : S_HIGH;
        end
      end
      S_DONE: begin
        if (!bus.Enable) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // High byte holding register; a stale value is harmless since every word
  // reloads it before use
  always_ff @(posedge Clock_50) begin
    if (load_hold) hold <= bus.Byte_data;
  end

  // Counters, write strobe and registered status. A pending write pulse
  // always retires (address/count advance) even if the session was aborted.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      lf_count   <= 8'd0;
      address    <= BASE_ADDRESS;
      write_data <= 16'd0;
      we_n       <= 1'b1;
      word_count <= 17'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (start_session) begin
        lf_count   <= 8'd0;
        address    <= BASE_ADDRESS;
        word_count <= 17'd0;
      end else begin
        if (count_lf) lf_count <= lf_count + 8'd1;
        if (!we_n) begin
          address    <= address + 18'd1;
          word_count <= word_count + 17'd1;
        end
      end
      we_n <= ~issue_write;
      if (issue_write) write_data <= {hold, bus.Byte_data};
      busy <= (next_state == S_HEADER) || (next_state == S_HIGH) || (next_state == S_LOW);
      done <= (next_state == S_DONE);
    end
  end

  assign bus.SRAM_address    = address;
  assign bus.SRAM_write_data = write_data;
  assign bus.SRAM_we_n       = we_n;
  assign bus.Word_count      = word_count;
  assign bus.Busy            = busy;
  assign bus.Done            = done;

endmodule

// File: tb/tb_ppm_sram_writer.sv
// Directed bench for ppm_sram_writer with a 4-word frame at base 0x100.
module tb_ppm_sram_writer;

  localparam logic [17:0] BASE = 18'h00100;

  logic Clock_50;
  logic Resetn;

  ppm_sram_writer_if bus ();

  ppm_sram_writer #(
    .BASE_ADDRESS(BASE),
    .HEADER_LINES(3),
    .NUM_WORDS   (4)
  ) dut (
    .Clock_50(Clock_50),
    .Resetn  (Resetn),
    .bus     (bus)
  );

  initial Clock_50 = 1'b0;
  always #10 Clock_50 = ~Clock_50;

  int vectors    = 0;
  int miscompares = 0;

  // Write-port log, sampled a quarter period after each rising edge
  logic [17:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int          long_pulses = 0;
  logic        prev_low = 1'b0;

  always @(posedge Clock_50) begin
    #5;
    if (bus.SRAM_we_n === 1'b0) begin
      wr_addr.push_back(bus.SRAM_address);
      wr_data.push_back(bus.SRAM_write_data);
      if (prev_low) long_pulses <= long_pulses + 1;
    end
    prev_low <= (bus.SRAM_we_n === 1'b0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; presents one byte for exactly one cycle
  task automatic send(input logic [7:0] b);
    bus.Byte_valid = 1'b1;
    bus.Byte_data  = b;
    @(negedge Clock_50);
    bus.Byte_valid = 1'b0;
  endtask

  task automatic send_header();
    string hdr;
    hdr = "P6\n320 240\n255\n";
    for (int i = 0; i < hdr.len(); i++) send(hdr[i]);
  endtask

  int mark;

  initial begin
    Resetn         = 1'b0;
    bus.Enable     = 1'b0;
    bus.Byte_valid = 1'b0;
    bus.Byte_data  = 8'h00;
    @(negedge Clock_50);
    @(negedge Clock_50);

    // Reset values
    check("rst_addr", 32'(bus.SRAM_address), 32'(BASE));
    check("rst_data", 32'(bus.SRAM_write_data), 32'h0);
    check("rst_we_n", 32'(bus.SRAM_we_n), 32'h1);
    check("rst_count", 32'(bus.Word_count), 32'h0);
    check("rst_busy", 32'(bus.Busy), 32'h0);
    check("rst_done", 32'(bus.Done), 32'h0);
    Resetn = 1'b1;
    @(negedge Clock_50);

    // Header then a single word 0x1234
    bus.Enable = 1'b1;
    @(negedge Clock_50);
    check("t1_busy", 32'(bus.Busy), 32'h1);
    send_header();
    check("t1_hdr_nowrite", 32'(wr_addr.size()), 32'd0);
    send(8'h12);
    send(8'h34);
    check("t1_we_low", 32'(bus.SRAM_we_n), 32'h0);
    check("t1_addr", 32'(bus.SRAM_address), 32'(BASE));
    check("t1_data", 32'(bus.SRAM_write_data), 32'h1234);
    @(negedge Clock_50);
    check("t1_we_high", 32'(bus.SRAM_we_n), 32'h1);
    check("t1_addr_inc", 32'(bus.SRAM_address), 32'(BASE + 18'd1));
    check("t1_count", 32'(bus.Word_count), 32'd1);
    check("t1_nwrites", 32'(wr_addr.size()), 32'd1);

    // Rest of the frame, bytes on every cycle, ending in Done
    mark = wr_addr.size();
    send(8'hAB); send(8'hCD);
    send(8'h55); send(8'hAA);
    send(8'hFF); send(8'h00);
    check("t3_done", 32'(bus.Done), 32'h1);
    check("t3_busy", 32'(bus.Busy), 32'h0);
    @(negedge Clock_50);
    check("t3_count", 32'(bus.Word_count), 32'd4);
    check("t3_addr_end", 32'(bus.SRAM_address), 32'(BASE + 18'd4));
    check("t3_nwrites", 32'(wr_addr.size() - mark), 32'd3);
    if (wr_addr.size() - mark == 3) begin
      check("t3_a0", 32'(wr_addr[mark]),     32'(BASE + 18'd1));
      check("t3_d0", 32'(wr_data[mark]),     32'hABCD);
      check("t3_a1", 32'(wr_addr[mark + 1]), 32'(BASE + 18'd2));
      check("t3_d1", 32'(wr_data[mark + 1]), 32'h55AA);
      check("t3_a2", 32'(wr_addr[mark + 2]), 32'(BASE + 18'd3));
      check("t3_d2", 32'(wr_data[mark + 2]), 32'hFF00);
    end

    // Bytes after Done are ignored
    mark = wr_addr.size();
    for (int i = 0; i < 10; i++) send(8'(i * 7 + 8'h0A));
    @(negedge Clock_50);
    check("t6_nowrite", 32'(wr_addr.size() - mark), 32'd0);
    check("t6_done", 32'(bus.Done), 32'h1);
    check("t6_count", 32'(bus.Word_count), 32'd4);
    check("t6_addr", 32'(bus.SRAM_address), 32'(BASE + 18'd4));
    bus.Enable = 1'b0;
    @(negedge Clock_50);
    check("t6_done_clr", 32'(bus.Done), 32'h0);

    // Abort after three payload bytes: only the first word is written
    bus.Enable = 1'b1;
    @(negedge Clock_50);
    send_header();
    mark = wr_addr.size();
    send(8'h11); send(8'h22); send(8'h33);
    bus.Enable = 1'b0;
    repeat (3) @(negedge Clock_50);
    check("t4_nwrites", 32'(wr_addr.size() - mark), 32'd1);
    if (wr_addr.size() - mark == 1) begin
      check("t4_addr", 32'(wr_addr[mark]), 32'(BASE));
      check("t4_data", 32'(wr_data[mark]), 32'h1122);
    end
    check("t4_busy", 32'(bus.Busy), 32'h0);
    check("t4_count", 32'(bus.Word_count), 32'd1);
    bus.Enable = 1'b1;
    @(negedge Clock_50);
    check("t4_re_addr", 32'(bus.SRAM_address), 32'(BASE));
    check("t4_re_count", 32'(bus.Word_count), 32'd0);
    check("t4_re_busy", 32'(bus.Busy), 32'h1);

    // CR bytes in the header are not line terminators
    mark = wr_addr.size();
    send(8'h0D); send(8'h0A); send(8'h0D); send(8'h0A);
    send(8'h0D); send(8'h0D); send(8'h0A);
    @(negedge Clock_50);
    check("t6_cr_nowrite", 32'(wr_addr.size() - mark), 32'd0);
    send(8'h56); send(8'h78);
    @(negedge Clock_50);
    check("t6_cr_nwrites", 32'(wr_addr.size() - mark), 32'd1);
    if (wr_addr.size() - mark == 1) begin
      check("t6_cr_addr", 32'(wr_addr[mark]), 32'(BASE));
      check("t6_cr_data", 32'(wr_data[mark]), 32'h5678);
    end

    // Asynchronous reset while waiting for a low byte
    send(8'h9A);
    mark = wr_addr.size();
    bus.Byte_valid = 1'b1;
    bus.Byte_data  = 8'hBC;
    #5;
    Resetn = 1'b0;
    #1;
    check("t5_we_n", 32'(bus.SRAM_we_n), 32'h1);
    check("t5_addr", 32'(bus.SRAM_address), 32'(BASE));
    check("t5_data", 32'(bus.SRAM_write_data), 32'h0);
    check("t5_count", 32'(bus.Word_count), 32'd0);
    check("t5_busy", 32'(bus.Busy), 32'h0);
    @(negedge Clock_50);
    bus.Byte_valid = 1'b0;
    check("t5_we_n_hold", 32'(bus.SRAM_we_n), 32'h1);
    check("t5_nowrite", 32'(wr_addr.size() - mark), 32'd0);
    Resetn = 1'b1;
    @(negedge Clock_50);

    check("pulse_width", 32'(long_pulses), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
